// File: rtl/fc_vec_loader.sv
// ----------------------------------------------------------------------------
// fc_vec_loader
//
// Producer side of a fully-connected neuron layer. Activations arrive one per
// beat on a valid/ready stream and are assembled into the parallel array x that
// feeds the layer's combinational adder tree. Once a vector is complete, x is
// frozen for SETTLE cycles so the tree can settle. The layer output z is then
// captured and offered on a valid/ready result stream. Only one x buffer
// exists, so a new vector is not accepted until the result has been taken.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   s_valid  in   activation beat valid
//   s_ready  out  block accepts an activation beat (state FILL)
//   s_data   in   activation value, WIDTH bits
//   s_last   in   final beat of the vector
//   x        out  registered activation array [0:IN-1], drives layer.x
//   z        in   layer result, RES_W bits, driven by layer.z
//   m_valid  out  result valid
//   m_ready  in   downstream accepts the result
//   m_data   out  captured result
//   len_err  out  one-cycle pulse: s_last did not line up with beat IN-1
// ----------------------------------------------------------------------------
module fc_vec_loader #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int RES_W  = 22,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  input  logic [RES_W-1:0] z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [RES_W-1:0] m_data,
  output logic             len_err
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_x [0:IN-1];
  logic [RES_W-1:0] r_mdata;
  logic             r_mvalid;
  logic             r_len_err;

  logic             w_accept;
  logic             w_at_last;
  logic             w_final;
  logic             w_len_err;
  logic             w_capture;
  logic             w_release;

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_at_last   = (r_idx == LAST_IDX);
    w_final     = 1'b0;
    w_len_err   = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (s_valid) begin
          w_accept = 1'b1;
          // The vector closes on s_last or when the array is full, whichever
          // comes first; any disagreement between the two is a length error.
          w_final  = s_last || w_at_last;
          w_len_err = w_final && (s_last != w_at_last);
          if (w_final) begin
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control registers: beat index, settle counter, result valid, error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_mvalid  <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_len_err;

      // idx parks on the final beat's slot until the result is released,
      // so it never exceeds IN-1.
      if (w_accept && !w_final) begin
        r_idx <= r_idx + 1'b1;
      end else if (w_release) begin
        r_idx <= '0;
      end

      if (w_final) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == ST_SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        r_mvalid <= 1'b1;
      end else if (w_release) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  // Datapath: activation array and captured result. The array is cleared on
  // release so that a short next vector sees zeros in its unwritten tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IN; i++) begin
        r_x[i] <= '0;
      end
      r_mdata <= '0;
    end else begin
      for (int i = 0; i < IN; i++) begin
        if (w_release) begin
          r_x[i] <= '0;
        end else if (w_accept && (r_idx == IDX_W'(i))) begin
          r_x[i] <= s_data;
        end
      end
      if (w_capture) begin
        r_mdata <= z;
      end
    end
  end

  assign s_ready = (r_state == ST_FILL);
  assign x       = r_x;
  assign m_valid = r_mvalid;
  assign m_data  = r_mdata;
  assign len_err = r_len_err;

endmodule
